// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Scancodes are set 2; digit keys are the top-row numerals.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    localparam logic [7:0] KEY_0 = 8'h45;
    localparam logic [7:0] KEY_1 = 8'h16;
    localparam logic [7:0] KEY_2 = 8'h1E;
    localparam logic [7:0] KEY_3 = 8'h26;
    localparam logic [7:0] KEY_4 = 8'h25;
    localparam logic [7:0] KEY_5 = 8'h2E;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h3D;
    localparam logic [7:0] KEY_8 = 8'h3E;
    localparam logic [7:0] KEY_9 = 8'h46;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    // 4'hF marks a non-digit code.
    function automatic logic [3:0] digit_of(input logic [7:0] code);
        logic [3:0] v;
        case (code)
            KEY_0:   v = 4'd0;
            KEY_1:   v = 4'd1;
            KEY_2:   v = 4'd2;
            KEY_3:   v = 4'd3;
            KEY_4:   v = 4'd4;
            KEY_5:   v = 4'd5;
            KEY_6:   v = 4'd6;
            KEY_7:   v = 4'd7;
            KEY_8:   v = 4'd8;
            KEY_9:   v = 4'd9;
            default: v = 4'hF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO for decoded key events.
// Head data reads as zero while empty.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop in the same cycle frees the slot a full push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync, clock filter, frame FSM,
// prefix folding, event FIFO and numeric LED display.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4,
    parameter int LED_WIDTH      = 16
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 PS2Clock,
    input  logic                 PS2Data,
    output logic                 EvValid,
    input  logic                 EvReady,
    output logic [7:0]           EvCode,
    output logic                 EvBreak,
    output logic                 EvExt,
    output logic                 FrameError,
    output logic                 Overflow,
    output logic [LED_WIDTH-1:0] led
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FLT_MAX = CW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] cs_q, cs_d, ds_q, ds_d;
    logic                   clk_s, data_s;
    logic                   filt_q, filt_d;
    logic [CW-1:0]          flt_cnt_q, flt_cnt_d;
    logic                   fall;

    state_e                 state_q, state_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   err_q, err_d;
    logic                   good_q, good_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [LED_WIDTH-1:0]   led_q, led_d;

    logic                   push, pop, full, empty;
    logic [3:0]             dig;
    ps2_event_t             ev_in, ev_out;

    assign clk_s  = cs_q[SYNC_STAGES-1];
    assign data_s = ds_q[SYNC_STAGES-1];

    always_comb begin
        cs_d      = {cs_q[SYNC_STAGES-2:0], PS2Clock};
        ds_d      = {ds_q[SYNC_STAGES-2:0], PS2Data};
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (flt_cnt_q == FLT_MAX) filt_d = clk_s;
            else flt_cnt_d = flt_cnt_q + CW'(1);
        end
        fall = filt_q & ~filt_d;
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = '0;
        err_d   = 1'b0;
        good_d  = 1'b0;
        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && (^{shift_q, par_q})) good_d = 1'b1;
                    else err_d = 1'b1;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // Byte is consumed the cycle after the stop bit; shift_q is still stable.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (good_q) begin
            if (shift_q == CODE_EXT) ext_d = 1'b1;
            else if (shift_q == CODE_BRK) brk_d = 1'b1;
            else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_comb begin
        dig   = digit_of(shift_q);
        led_d = led_q;
        if (push && !brk_q && !ext_q) begin
            if (dig == 4'hF) led_d = '1;
            else led_d = LED_WIDTH'(dig);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cs_q      <= '1;
            ds_q      <= '1;
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            good_q    <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            cs_q      <= cs_d;
            ds_q      <= ds_d;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            state_q   <= state_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            good_q    <= good_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            led_q     <= led_d;
        end
    end

    assign ev_in = '{code: shift_q, brk: brk_q, ext: ext_q};
    assign pop   = EvReady & ~empty;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clk   (Clock),
        .rst_n (ResetN),
        .push  (push),
        .pop   (pop),
        .din   (ev_in),
        .dout  (ev_out),
        .full  (full),
        .empty (empty)
    );

    assign EvValid    = ~empty;
    assign EvCode     = ev_out.code;
    assign EvBreak    = ev_out.brk;
    assign EvExt      = ev_out.ext;
    assign FrameError = err_q;
    assign Overflow   = push & full & ~pop;
    assign led        = led_q;

endmodule
